// File: rtl/uart_loopback_ctrl_if.sv
// RX FIFO read port, receiver error flags and TX FIFO write port.
// master: loopback controller side; slave: FIFO / receiver side.
interface uart_loopback_ctrl_if;
  logic       rx_rd_valid;
  logic [7:0] rx_rd_data;
  logic       rx_read_en;
  logic       rx_frame_err;
  logic       rx_parity_err;
  logic       tx_full;
  logic       tx_wr_en;
  logic [7:0] tx_wr_data;

  modport master (
    input  rx_rd_valid,
    input  rx_rd_data,
    input  rx_frame_err,
    input  rx_parity_err,
    input  tx_full,
    output rx_read_en,
    output tx_wr_en,
    output tx_wr_data
  );

  modport slave (
    output rx_rd_valid,
    output rx_rd_data,
    output rx_frame_err,
    output rx_parity_err,
    output tx_full,
    input  rx_read_en,
    input  tx_wr_en,
    input  tx_wr_data
  );
endinterface

// File: rtl/uart_loopback_ctrl.sv
// UART loopback sequencer: drains RX FIFO bytes into the TX FIFO and keeps
// byte / error statistics. Ports: mclk, n_reset (async low), enable,
// clr_cnt, bus (RX read + error flags + TX write, master modport), busy,
// byte_cnt (wraps), frame_err_cnt / parity_err_cnt (saturate).
// Optional: define UART_LOOPBACK_CRLF_EN to append 0x0A after each 0x0D.
module uart_loopback_ctrl #(
  parameter int CNT_W     = 16,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 mclk,
  input  logic                 n_reset,
  input  logic                 enable,
  input  logic                 clr_cnt,
  uart_loopback_ctrl_if.master bus,
  output logic                 busy,
  output logic [CNT_W-1:0]     byte_cnt,
  output logic [ERR_CNT_W-1:0] frame_err_cnt,
  output logic [ERR_CNT_W-1:0] parity_err_cnt
);

`ifdef UART_LOOPBACK_CRLF_EN
  typedef enum logic [2:0] {
    IDLE, RD, LAT, CAP, WR, LF
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, RD, LAT, CAP, WR
  } state_t;
`endif

  state_t     state_q;
  state_t     state_d;
  logic [7:0] hold_q;
  logic       rd_q;
  logic       rd_d;
  logic       wr_q;
  logic       wr_d;
  logic [7:0] wdata_q;
  logic [7:0] wdata_d;
  logic       cap;
  logic       cnt_inc;
  logic       fe_q;
  logic       pe_q;
  logic       fe_rise;
  logic       pe_rise;

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      wdata_q <= 8'h00;
      hold_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      wdata_q <= wdata_d;
      if (cap) hold_q <= bus.rx_rd_data;
    end
  end

  // Outputs are registered: the read strobe lands in LAT and the write
  // strobe lands in the cycle after WR accepts.
  always_comb begin
    state_d = state_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    wdata_d = wdata_q;
    cap     = 1'b0;
    cnt_inc = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (enable && bus.rx_rd_valid) state_d = RD;
      end
      RD: begin
        rd_d    = 1'b1;
        state_d = LAT;
      end
      LAT: begin
        state_d = CAP;
      end
      CAP: begin
        cap     = 1'b1;
        state_d = WR;
      end
      WR: begin
        if (!bus.tx_full) begin
          wr_d    = 1'b1;
          wdata_d = hold_q;
          cnt_inc = 1'b1;
          state_d = IDLE;
`ifdef UART_LOOPBACK_CRLF_EN
          if (hold_q == 8'h0D) state_d = LF;
`endif
        end
      end
`ifdef UART_LOOPBACK_CRLF_EN
      LF: begin
        if (!bus.tx_full) begin
          wr_d    = 1'b1;
          wdata_d = 8'h0A;
          state_d = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rx_read_en = rd_q;
  assign bus.tx_wr_en   = wr_q;
  assign bus.tx_wr_data = wdata_q;
  assign busy           = (state_q != IDLE);

  // Level flags count once per 0->1 transition.
  assign fe_rise = bus.rx_frame_err  & ~fe_q;
  assign pe_rise = bus.rx_parity_err & ~pe_q;

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      fe_q           <= 1'b0;
      pe_q           <= 1'b0;
      byte_cnt       <= '0;
      frame_err_cnt  <= '0;
      parity_err_cnt <= '0;
    end else begin
      fe_q <= bus.rx_frame_err;
      pe_q <= bus.rx_parity_err;
      if (clr_cnt) begin
        byte_cnt       <= '0;
        frame_err_cnt  <= '0;
        parity_err_cnt <= '0;
      end else begin
        if (cnt_inc)
          byte_cnt <= byte_cnt + CNT_W'(1);
        if (fe_rise && !(&frame_err_cnt))
          frame_err_cnt <= frame_err_cnt + ERR_CNT_W'(1);
        if (pe_rise && !(&parity_err_cnt))
          parity_err_cnt <= parity_err_cnt + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_uart_loopback_ctrl.sv
// Self-checking bench for uart_loopback_ctrl: FIFO model, expected-byte
// scoreboard, counter model and directed scenarios.
module tb_uart_loopback_ctrl;

`ifdef UART_LOOPBACK_CRLF_EN
  localparam bit CRLF = 1'b1;
`else
  localparam bit CRLF = 1'b0;
`endif

  logic        mclk = 1'b0;
  logic        n_reset = 1'b0;
  logic        enable = 1'b0;
  logic        clr_cnt = 1'b0;
  logic        busy;
  logic [15:0] byte_cnt;
  logic [7:0]  frame_err_cnt;
  logic [7:0]  parity_err_cnt;

  uart_loopback_ctrl_if bus ();

  uart_loopback_ctrl #(
    .CNT_W(16),
    .ERR_CNT_W(8)
  ) dut (
    .mclk(mclk),
    .n_reset(n_reset),
    .enable(enable),
    .clr_cnt(clr_cnt),
    .bus(bus),
    .busy(busy),
    .byte_cnt(byte_cnt),
    .frame_err_cnt(frame_err_cnt),
    .parity_err_cnt(parity_err_cnt)
  );

  always #5 mclk = ~mclk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] fifo_mem [64];
  logic [5:0] wp = '0;
  logic [5:0] rp = '0;
  logic [7:0] exp_mem [64];
  logic       exp_lf [64];
  logic [5:0] exp_wp = '0;
  logic [5:0] exp_rp = '0;

  int         r_cyc [64];
  int         w_cyc [64];
  logic [7:0] w_data [64];
  int         n_r = 0;
  int         n_w = 0;
  int         cyc = 0;

  logic [15:0] m_bytes = '0;
  logic [7:0]  m_fe = '0;
  logic [7:0]  m_pe = '0;
  logic        pf = 1'b0;
  logic        pp = 1'b0;
  logic        clr_at_edge = 1'b0;
  logic [7:0]  last_data = '0;

  assign bus.rx_rd_valid = (wp != rp);

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wp] = d;
    wp = wp + 6'd1;
    exp_mem[exp_wp] = d;
    exp_lf[exp_wp] = 1'b0;
    exp_wp = exp_wp + 6'd1;
    if (CRLF && d == 8'h0D) begin
      exp_mem[exp_wp] = 8'h0A;
      exp_lf[exp_wp] = 1'b1;
      exp_wp = exp_wp + 6'd1;
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge mclk);
    #2;
  endtask

  task automatic drain(input int maxc);
    int k = 0;
    while ((busy || wp != rp || exp_rp != exp_wp) && k < maxc) begin
      step(1);
      k++;
    end
    chk("drain_timeout", 32'(k < maxc), 32'd1);
    step(2);
  endtask

  // Counter model: error counters follow flag rises, clear wins.
  task automatic edge_model();
    forever begin
      @(posedge mclk or negedge n_reset);
      if (!n_reset) begin
        m_fe = '0;
        m_pe = '0;
        pf = 1'b0;
        pp = 1'b0;
        clr_at_edge = 1'b0;
      end else begin
        cyc++;
        clr_at_edge = clr_cnt;
        if (clr_cnt) begin
          m_fe = '0;
          m_pe = '0;
        end else begin
          if (bus.rx_frame_err && !pf && m_fe != 8'hFF)
            m_fe = m_fe + 8'd1;
          if (bus.rx_parity_err && !pp && m_pe != 8'hFF)
            m_pe = m_pe + 8'd1;
        end
        pf = bus.rx_frame_err;
        pp = bus.rx_parity_err;
      end
    end
  endtask

  // FIFO model and per-cycle output compare.
  task automatic monitor();
    forever begin
      @(negedge mclk);
      if (!n_reset) begin
        exp_rp = exp_wp;
        m_bytes = '0;
        last_data = '0;
      end else begin
        if (bus.rx_read_en) begin
          r_cyc[n_r % 64] = cyc;
          n_r++;
          chk("read_empty", 32'(wp != rp), 32'd1);
          if (wp != rp) begin
            bus.rx_rd_data = fifo_mem[rp];
            rp = rp + 6'd1;
          end
        end
        if (clr_at_edge) m_bytes = '0;
        if (bus.tx_wr_en) begin
          w_cyc[n_w % 64] = cyc;
          w_data[n_w % 64] = bus.tx_wr_data;
          n_w++;
          chk("unexpected_write", 32'(exp_rp != exp_wp), 32'd1);
          if (exp_rp != exp_wp) begin
            chk("tx_data", 32'(bus.tx_wr_data), 32'(exp_mem[exp_rp]));
            if (!exp_lf[exp_rp] && !clr_at_edge)
              m_bytes = m_bytes + 16'd1;
            exp_rp = exp_rp + 6'd1;
          end
          last_data = bus.tx_wr_data;
        end else begin
          chk("tx_hold", 32'(bus.tx_wr_data), 32'(last_data));
        end
        chk("byte_cnt", 32'(byte_cnt), 32'(m_bytes));
        chk("frame_cnt", 32'(frame_err_cnt), 32'(m_fe));
        chk("parity_cnt", 32'(parity_err_cnt), 32'(m_pe));
      end
    end
  endtask

  initial begin
    int br;
    int bw;
    int k;
    int exp_n;
    bus.tx_full = 1'b0;
    bus.rx_frame_err = 1'b0;
    bus.rx_parity_err = 1'b0;
    bus.rx_rd_data = 8'h00;
    fork
      edge_model();
      monitor();
    join_none

    // Reset state
    step(2);
    chk("rst_rd_en", 32'(bus.rx_read_en), 32'd0);
    chk("rst_wr_en", 32'(bus.tx_wr_en), 32'd0);
    chk("rst_wr_data", 32'(bus.tx_wr_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("rst_fe_cnt", 32'(frame_err_cnt), 32'd0);
    chk("rst_pe_cnt", 32'(parity_err_cnt), 32'd0);
    n_reset = 1'b1;
    step(2);

    // Two bytes, no back-pressure
    br = n_r;
    bw = n_w;
    push(8'h55);
    push(8'hA3);
    enable = 1'b1;
    drain(100);
    chk("basic_nw", 32'(n_w - bw), 32'd2);
    chk("basic_nr", 32'(n_r - br), 32'd2);
    chk("basic_d0", 32'(w_data[bw % 64]), 32'h55);
    chk("basic_d1", 32'(w_data[(bw + 1) % 64]), 32'hA3);
    chk("basic_gap0", 32'(w_cyc[bw % 64] - r_cyc[br % 64]), 32'd3);
    chk("basic_gap1",
        32'(w_cyc[(bw + 1) % 64] - r_cyc[(br + 1) % 64]), 32'd3);
    chk("basic_cnt", 32'(byte_cnt), 32'd2);
    chk("basic_model_cnt", 32'(m_bytes), 32'd2);
    chk("basic_busy", 32'(busy), 32'd0);

    // Back-pressure
    br = n_r;
    bw = n_w;
    bus.tx_full = 1'b1;
    push(8'h3C);
    push(8'h99);
    step(25);
    chk("bp_no_write", 32'(n_w - bw), 32'd0);
    chk("bp_one_read", 32'(n_r - br), 32'd1);
    chk("bp_busy", 32'(busy), 32'd1);
    bus.tx_full = 1'b0;
    k = cyc;
    drain(100);
    chk("bp_d0", 32'(w_data[bw % 64]), 32'h3C);
    chk("bp_when", 32'(w_cyc[bw % 64]), 32'(k + 1));
    chk("bp_d1", 32'(w_data[(bw + 1) % 64]), 32'h99);
    chk("bp_cnt", 32'(byte_cnt), 32'd4);

    // enable dropped right after the read strobe
    br = n_r;
    bw = n_w;
    push(8'h7E);
    push(8'h11);
    k = 0;
    while (n_r == br && k < 20) begin
      step(1);
      k++;
    end
    chk("en_read_seen", 32'(n_r - br), 32'd1);
    enable = 1'b0;
    step(20);
    chk("en_nw", 32'(n_w - bw), 32'd1);
    chk("en_d0", 32'(w_data[bw % 64]), 32'h7E);
    chk("en_nr", 32'(n_r - br), 32'd1);
    chk("en_busy", 32'(busy), 32'd0);
    chk("en_cnt", 32'(byte_cnt), 32'd5);
    enable = 1'b1;
    drain(100);
    chk("en_d1", 32'(w_data[(bw + 1) % 64]), 32'h11);
    chk("en_cnt2", 32'(byte_cnt), 32'd6);
    enable = 1'b0;

    // Error edges
    for (int i = 0; i < 3; i++) begin
      bus.rx_frame_err = 1'b1;
      step(1);
      bus.rx_frame_err = 1'b0;
      step(1);
    end
    bus.rx_frame_err = 1'b1;
    step(10);
    bus.rx_frame_err = 1'b0;
    step(2);
    chk("fe_cnt", 32'(frame_err_cnt), 32'd4);
    chk("fe_model", 32'(m_fe), 32'd4);
    for (int i = 0; i < 300; i++) begin
      bus.rx_parity_err = 1'b1;
      step(1);
      bus.rx_parity_err = 1'b0;
      step(1);
    end
    step(1);
    chk("pe_sat", 32'(parity_err_cnt), 32'd255);
    chk("pe_model", 32'(m_pe), 32'd255);
    bus.rx_frame_err = 1'b1;
    clr_cnt = 1'b1;
    step(1);
    clr_cnt = 1'b0;
    bus.rx_frame_err = 1'b0;
    step(1);
    chk("clr_fe", 32'(frame_err_cnt), 32'd0);
    chk("clr_pe", 32'(parity_err_cnt), 32'd0);
    chk("clr_bytes", 32'(byte_cnt), 32'd0);
    bus.rx_frame_err = 1'b1;
    step(2);
    bus.rx_frame_err = 1'b0;
    chk("fe_after_clr", 32'(frame_err_cnt), 32'd1);

    // CR handling
    bw = n_w;
    exp_n = CRLF ? 3 : 2;
    push(8'h41);
    push(8'h0D);
    enable = 1'b1;
    drain(100);
    chk("cr_nw", 32'(n_w - bw), 32'(exp_n));
    chk("cr_d0", 32'(w_data[bw % 64]), 32'h41);
    chk("cr_d1", 32'(w_data[(bw + 1) % 64]), 32'h0D);
`ifdef UART_LOOPBACK_CRLF_EN
    chk("cr_lf", 32'(w_data[(bw + 2) % 64]), 32'h0A);
`endif
    chk("cr_cnt", 32'(byte_cnt), 32'd2);
    chk("cr_busy", 32'(busy), 32'd0);

    // Reset while stalled in WR
    bw = n_w;
    bus.tx_full = 1'b1;
    push(8'h42);
    step(8);
    chk("mid_busy", 32'(busy), 32'd1);
    n_reset = 1'b0;
    #1;
    chk("mid_rd_en", 32'(bus.rx_read_en), 32'd0);
    chk("mid_wr_en", 32'(bus.tx_wr_en), 32'd0);
    chk("mid_wr_data", 32'(bus.tx_wr_data), 32'd0);
    chk("mid_busy_rst", 32'(busy), 32'd0);
    chk("mid_byte_cnt", 32'(byte_cnt), 32'd0);
    chk("mid_fe_cnt", 32'(frame_err_cnt), 32'd0);
    step(2);
    enable = 1'b0;
    bus.tx_full = 1'b0;
    n_reset = 1'b1;
    step(4);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_nw", 32'(n_w - bw), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule
